// File: rtl/dbus_uncache_axi_pkg.sv
// Shared types for the uncached dbus-to-AXI bridge: physical address, AXI
// request/response bundles, protocol constants and the bridge FSM states.
package dbus_uncache_axi_pkg;

    typedef logic [31:0] phys_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef struct packed {
        // AR channel
        phys_t       araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arlock;
        logic [3:0]  arcache;
        logic [2:0]  arprot;
        logic        arvalid;
        // R channel
        logic        rready;
        // AW channel
        phys_t       awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awlock;
        logic [3:0]  awcache;
        logic [2:0]  awprot;
        logic        awvalid;
        // W channel
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        // B channel
        logic        bready;
    } axi_req_t;

    typedef struct packed {
        logic        arready;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        rvalid;
        logic        awready;
        logic        wready;
        logic [1:0]  bresp;
        logic        bvalid;
    } axi_resp_t;

    typedef enum logic [2:0] {
        StIdle,
        StRdAddr,
        StRdData,
        StWrReq,
        StWrResp,
        StDone
    } uncache_state_t;

    // dbus size is log2(bytes) in 2 bits; AXI size is the same value in 3 bits.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/dbus_uncache_axi_if.sv
// CPU/D$ data-bus request interface. The master issues one request at a time;
// the slave answers with addr_ok (accept) and later data_ok (completion).
interface cpu_dbus_if;
    import dbus_uncache_axi_pkg::*;

    logic        valid;
    logic        op;        // 0 = read, 1 = write
    logic        uncache;
    phys_t       address;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output valid, op, uncache, address, size, wdata, wstrb,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  valid, op, uncache, address, size, wdata, wstrb,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/dbus_uncache_axi.sv
// Uncached dbus bridge: turns each accepted dbus request into exactly one
// single-beat AXI read or write. One transaction in flight at a time.
module dbus_uncache_axi
    import dbus_uncache_axi_pkg::*;
#(
    parameter logic [3:0] AXI_CACHE = 4'b0000,
    parameter logic [2:0] AXI_PROT  = 3'b000
) (
    input  logic       clk,
    input  logic       resetn,
    cpu_dbus_if.slave  dbus,
    output axi_req_t   axi_req,
    input  axi_resp_t  axi_resp,
    output logic       bus_err
);

    uncache_state_t r_state, w_state_nxt;
    phys_t          r_addr, w_addr_nxt;
    logic [1:0]     r_size, w_size_nxt;
    logic [31:0]    r_wdata, w_wdata_nxt;
    logic [3:0]     r_wstrb, w_wstrb_nxt;
    logic [31:0]    r_rdata, w_rdata_nxt;
    logic           r_err, w_err_nxt;
    logic           r_aw_done, w_aw_done_nxt;
    logic           r_w_done, w_w_done_nxt;

    logic w_aw_fire;
    logic w_w_fire;

    // Request direction is carried by the state itself, so op is not latched.
    // uncache=0 requests are serviced identically; rlast is redundant for one beat.
    logic w_unused;
    assign w_unused = ^{dbus.uncache, axi_resp.rlast};

    assign w_aw_fire = (r_state == StWrReq) && !r_aw_done && axi_resp.awready;
    assign w_w_fire  = (r_state == StWrReq) && !r_w_done && axi_resp.wready;

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= StIdle;
            r_addr    <= '0;
            r_size    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_size    <= w_size_nxt;
            r_wdata   <= w_wdata_nxt;
            r_wstrb   <= w_wstrb_nxt;
            r_rdata   <= w_rdata_nxt;
            r_err     <= w_err_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
        end
    end

    // Next-state and latch updates.
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_size_nxt    = r_size;
        w_wdata_nxt   = r_wdata;
        w_wstrb_nxt   = r_wstrb;
        w_rdata_nxt   = r_rdata;
        w_err_nxt     = r_err;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;

        unique case (r_state)
            StIdle: begin
                if (dbus.valid) begin
                    w_addr_nxt  = dbus.address;
                    w_size_nxt  = dbus.size;
                    w_wdata_nxt = dbus.wdata;
                    w_wstrb_nxt = dbus.wstrb;
                    w_state_nxt = dbus.op ? StWrReq : StRdAddr;
                end
            end
            StRdAddr: begin
                if (axi_resp.arready) begin
                    w_state_nxt = StRdData;
                end
            end
            StRdData: begin
                if (axi_resp.rvalid) begin
                    w_rdata_nxt = axi_resp.rdata;
                    w_err_nxt   = (axi_resp.rresp != AXI_RESP_OKAY);
                    w_state_nxt = StDone;
                end
            end
            StWrReq: begin
                // AW and W complete independently, in either order or together.
                if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_state_nxt   = StWrResp;
                end else begin
                    w_aw_done_nxt = r_aw_done || w_aw_fire;
                    w_w_done_nxt  = r_w_done || w_w_fire;
                end
            end
            StWrResp: begin
                if (axi_resp.bvalid) begin
                    w_err_nxt   = (axi_resp.bresp != AXI_RESP_OKAY);
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // AXI master outputs: fields come from the latch, valids/readies from state.
    always_comb begin
        axi_req         = '0;
        axi_req.araddr  = r_addr;
        axi_req.arlen   = 8'd0;
        axi_req.arsize  = axi_size(r_size);
        axi_req.arburst = AXI_BURST_INCR;
        axi_req.arlock  = 1'b0;
        axi_req.arcache = AXI_CACHE;
        axi_req.arprot  = AXI_PROT;
        axi_req.arvalid = (r_state == StRdAddr);
        axi_req.rready  = (r_state == StRdData);
        axi_req.awaddr  = r_addr;
        axi_req.awlen   = 8'd0;
        axi_req.awsize  = axi_size(r_size);
        axi_req.awburst = AXI_BURST_INCR;
        axi_req.awlock  = 1'b0;
        axi_req.awcache = AXI_CACHE;
        axi_req.awprot  = AXI_PROT;
        axi_req.awvalid = (r_state == StWrReq) && !r_aw_done;
        axi_req.wdata   = r_wdata;
        axi_req.wstrb   = r_wstrb;
        axi_req.wlast   = (r_state == StWrReq);
        axi_req.wvalid  = (r_state == StWrReq) && !r_w_done;
        axi_req.bready  = (r_state == StWrResp);
    end

    assign dbus.addr_ok = (r_state == StIdle);
    assign dbus.data_ok = (r_state == StDone);
    assign dbus.rdata   = r_rdata;
    assign bus_err      = (r_state == StDone) && r_err;

endmodule

// File: tb/tb_dbus_uncache_axi.sv
// Directed bench for dbus_uncache_axi: a configurable-wait AXI slave, a
// handshake monitor, and hand-computed latency/field expectations per request.
module tb_dbus_uncache_axi;
    import dbus_uncache_axi_pkg::*;

    logic      clk;
    logic      resetn;
    axi_req_t  axi_req;
    axi_resp_t axi_resp;
    logic      bus_err;

    cpu_dbus_if dbus_if ();

    dbus_uncache_axi #(
        .AXI_CACHE(4'b0000),
        .AXI_PROT (3'b000)
    ) u_dut (
        .clk     (clk),
        .resetn  (resetn),
        .dbus    (dbus_if),
        .axi_req (axi_req),
        .axi_resp(axi_resp),
        .bus_err (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave configuration: cycles of valid before ready per channel.
    int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
    logic [31:0] rd_word = 32'h0;
    logic [1:0]  rd_resp = 2'b00;
    logic [1:0]  wr_resp = 2'b00;

    // Handshake counters and captured beats.
    int          ar_hs = 0, r_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0;
    phys_t       cap_araddr, cap_awaddr;
    logic [2:0]  cap_arsize, cap_awsize;
    logic [7:0]  cap_arlen;
    logic [1:0]  cap_arburst;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_wlast;
    int          last_w_after_aw, last_aw_after_w;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // AXI slave: drives ready/valid on the negedge after counting wait cycles.
    initial begin
        int ar_seen, r_seen, aw_seen, w_seen, b_seen;
        ar_seen = 0; r_seen = 0; aw_seen = 0; w_seen = 0; b_seen = 0;
        axi_resp = '0;
        axi_resp.rlast = 1'b1;
        forever begin
            @(negedge clk);
            if (axi_req.arvalid) begin
                axi_resp.arready = (ar_seen == ar_wait); ar_seen++;
            end else begin
                axi_resp.arready = 1'b0; ar_seen = 0;
            end
            if (axi_req.rready) begin
                axi_resp.rvalid = (r_seen == r_wait); r_seen++;
            end else begin
                axi_resp.rvalid = 1'b0; r_seen = 0;
            end
            if (axi_req.awvalid) begin
                axi_resp.awready = (aw_seen == aw_wait); aw_seen++;
            end else begin
                axi_resp.awready = 1'b0; aw_seen = 0;
            end
            if (axi_req.wvalid) begin
                axi_resp.wready = (w_seen == w_wait); w_seen++;
            end else begin
                axi_resp.wready = 1'b0; w_seen = 0;
            end
            if (axi_req.bready) begin
                axi_resp.bvalid = (b_seen == b_wait); b_seen++;
            end else begin
                axi_resp.bvalid = 1'b0; b_seen = 0;
            end
            axi_resp.rdata = rd_word;
            axi_resp.rresp = rd_resp;
            axi_resp.bresp = wr_resp;
        end
    end

    // Handshake monitor on the active edge (values are pre-update here).
    initial begin
        forever begin
            @(posedge clk);
            if (resetn) begin
                if (axi_req.arvalid && axi_resp.arready) begin
                    ar_hs++;
                    cap_araddr  = axi_req.araddr;
                    cap_arsize  = axi_req.arsize;
                    cap_arlen   = axi_req.arlen;
                    cap_arburst = axi_req.arburst;
                end
                if (axi_req.rready && axi_resp.rvalid) r_hs++;
                if (axi_req.awvalid && axi_resp.awready) begin
                    aw_hs++;
                    cap_awaddr = axi_req.awaddr;
                    cap_awsize = axi_req.awsize;
                end
                if (axi_req.wvalid && axi_resp.wready) begin
                    w_hs++;
                    cap_wdata = axi_req.wdata;
                    cap_wstrb = axi_req.wstrb;
                    cap_wlast = axi_req.wlast;
                end
                if (axi_req.bready && axi_resp.bvalid) b_hs++;
            end
        end
    end

    // Issue one request from an IDLE negedge and check it through to IDLE again.
    task automatic run_req(input string tag, input logic op, input phys_t addr,
                           input logic [1:0] size, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int exp_lat, input logic exp_err,
                           input logic [31:0] exp_rdata, input logic hold);
        int ar0, r0, aw0, w0, b0;
        int cnt, addr_busy, early_err, aw_stuck, w_stuck, w_after_aw, aw_after_w;
        ar0 = ar_hs; r0 = r_hs; aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        check_eq({tag, "_idle_addr_ok"}, dbus_if.addr_ok, 1);
        dbus_if.valid   = 1'b1;
        dbus_if.op      = op;
        dbus_if.uncache = 1'b1;
        dbus_if.address = addr;
        dbus_if.size    = size;
        dbus_if.wdata   = wdata;
        dbus_if.wstrb   = wstrb;
        tick();
        dbus_if.valid = hold;
        cnt = 0; addr_busy = 0; early_err = 0; aw_stuck = 0; w_stuck = 0;
        w_after_aw = 0; aw_after_w = 0;
        while (!dbus_if.data_ok && cnt < 100) begin
            if (dbus_if.addr_ok) addr_busy++;
            if (bus_err) early_err++;
            if (aw_hs > aw0 && axi_req.awvalid) aw_stuck++;
            if (w_hs > w0 && axi_req.wvalid) w_stuck++;
            if (aw_hs > aw0 && axi_req.wvalid) w_after_aw++;
            if (w_hs > w0 && axi_req.awvalid) aw_after_w++;
            tick();
            cnt++;
        end
        last_w_after_aw = w_after_aw;
        last_aw_after_w = aw_after_w;
        check_eq({tag, "_data_ok"}, dbus_if.data_ok, 1);
        check_eq({tag, "_latency"}, cnt, exp_lat);
        check_eq({tag, "_addr_ok_busy"}, addr_busy, 0);
        check_eq({tag, "_addr_ok_done"}, dbus_if.addr_ok, 0);
        check_eq({tag, "_bus_err_early"}, early_err, 0);
        check_eq({tag, "_bus_err"}, bus_err, exp_err);
        if (!op) begin
            check_eq({tag, "_rdata"}, dbus_if.rdata, exp_rdata);
            check_eq({tag, "_ar_count"}, ar_hs - ar0, 1);
            check_eq({tag, "_r_count"}, r_hs - r0, 1);
            check_eq({tag, "_aw_count"}, aw_hs - aw0, 0);
            check_eq({tag, "_araddr"}, cap_araddr, addr);
            check_eq({tag, "_arsize"}, cap_arsize, {1'b0, size});
            check_eq({tag, "_arlen"}, cap_arlen, 0);
            check_eq({tag, "_arburst"}, cap_arburst, 2'b01);
        end else begin
            check_eq({tag, "_aw_count"}, aw_hs - aw0, 1);
            check_eq({tag, "_w_count"}, w_hs - w0, 1);
            check_eq({tag, "_b_count"}, b_hs - b0, 1);
            check_eq({tag, "_ar_count"}, ar_hs - ar0, 0);
            check_eq({tag, "_awaddr"}, cap_awaddr, addr);
            check_eq({tag, "_awsize"}, cap_awsize, {1'b0, size});
            check_eq({tag, "_wdata"}, cap_wdata, wdata);
            check_eq({tag, "_wstrb"}, cap_wstrb, wstrb);
            check_eq({tag, "_wlast"}, cap_wlast, 1);
            check_eq({tag, "_aw_after_hs"}, aw_stuck, 0);
            check_eq({tag, "_w_after_hs"}, w_stuck, 0);
        end
        tick();
        check_eq({tag, "_data_ok_pulse"}, dbus_if.data_ok, 0);
        check_eq({tag, "_bus_err_pulse"}, bus_err, 0);
        check_eq({tag, "_back_idle"}, dbus_if.addr_ok, 1);
    endtask

    initial begin
        int cnt;
        resetn          = 1'b0;
        dbus_if.valid   = 1'b0;
        dbus_if.op      = 1'b0;
        dbus_if.uncache = 1'b1;
        dbus_if.address = '0;
        dbus_if.size    = 2'd0;
        dbus_if.wdata   = '0;
        dbus_if.wstrb   = '0;
        tick();
        tick();
        check_eq("rst_addr_ok", dbus_if.addr_ok, 1);
        check_eq("rst_data_ok", dbus_if.data_ok, 0);
        check_eq("rst_bus_err", bus_err, 0);
        check_eq("rst_rdata", dbus_if.rdata, 0);
        check_eq("rst_arvalid", axi_req.arvalid, 0);
        check_eq("rst_rready", axi_req.rready, 0);
        check_eq("rst_awvalid", axi_req.awvalid, 0);
        check_eq("rst_wvalid", axi_req.wvalid, 0);
        check_eq("rst_bready", axi_req.bready, 0);
        check_eq("rst_wlast", axi_req.wlast, 0);
        resetn = 1'b1;
        tick();

        // Zero-wait read: accept T0, AR T1, R T2, data_ok T3.
        rd_word = 32'hdead_beef;
        run_req("rd0", 1'b0, 32'h1faf_f000, 2'd2, 32'h0, 4'h0, 2, 1'b0, 32'hdead_beef, 1'b0);

        // Read with AR and R waits: 2 + 1 + 2.
        ar_wait = 1; r_wait = 2; rd_word = 32'h0bad_f00d;
        run_req("rdw", 1'b0, 32'h1faf_f008, 2'd1, 32'h0, 4'h0, 5, 1'b0, 32'h0bad_f00d, 1'b0);
        ar_wait = 0; r_wait = 0;

        // AW three cycles before W: latency max(0,3) + 0 + 2.
        aw_wait = 0; w_wait = 3; b_wait = 0;
        run_req("wr_awfirst", 1'b1, 32'h1faf_f004, 2'd2, 32'h1234_5678, 4'b0011, 5, 1'b0,
                32'h0, 1'b0);
        check_eq("wr_awfirst_wvalid_held", last_w_after_aw, 3);

        // W before AW: latency max(2,0) + 1 + 2.
        aw_wait = 2; w_wait = 0; b_wait = 1;
        run_req("wr_wfirst", 1'b1, 32'h1faf_f00c, 2'd0, 32'h0000_00a5, 4'b0001, 5, 1'b0,
                32'h0, 1'b0);
        check_eq("wr_wfirst_awvalid_held", last_aw_after_w, 2);

        // Same-cycle AW/W: latency 1 + 0 + 2.
        aw_wait = 1; w_wait = 1; b_wait = 0;
        run_req("wr_same", 1'b1, 32'h1faf_f010, 2'd2, 32'hcafe_0001, 4'b1111, 3, 1'b0,
                32'h0, 1'b0);
        check_eq("wr_same_w_after_aw", last_w_after_aw, 0);
        check_eq("wr_same_aw_after_w", last_aw_after_w, 0);
        aw_wait = 0; w_wait = 0; b_wait = 0;

        // Back-to-back with valid held high through DONE.
        rd_word = 32'h5555_aaaa;
        run_req("b2b_rd", 1'b0, 32'h1faf_f020, 2'd2, 32'h0, 4'h0, 2, 1'b0, 32'h5555_aaaa, 1'b1);
        run_req("b2b_wr", 1'b1, 32'h1faf_f024, 2'd2, 32'h8765_4321, 4'b1100, 2, 1'b0,
                32'h5555_aaaa, 1'b0);

        // Error responses.
        rd_resp = 2'b10; rd_word = 32'h0000_0001;
        run_req("rd_err", 1'b0, 32'h1faf_f030, 2'd2, 32'h0, 4'h0, 2, 1'b1, 32'h0000_0001, 1'b0);
        rd_resp = 2'b00;
        wr_resp = 2'b11;
        run_req("wr_err", 1'b1, 32'h1faf_f034, 2'd2, 32'h0000_0002, 4'b1111, 2, 1'b1,
                32'h0, 1'b0);
        wr_resp = 2'b00;

        // Reset while waiting in RD_DATA with rvalid low.
        r_wait = 20;
        dbus_if.valid   = 1'b1;
        dbus_if.op      = 1'b0;
        dbus_if.address = 32'h1faf_f040;
        dbus_if.size    = 2'd2;
        tick();
        dbus_if.valid = 1'b0;
        cnt = 0;
        while (!axi_req.rready && cnt < 10) begin
            tick();
            cnt++;
        end
        check_eq("mid_rst_in_rd_data", axi_req.rready, 1);
        #2 resetn = 1'b0;
        #1;
        check_eq("mid_rst_arvalid", axi_req.arvalid, 0);
        check_eq("mid_rst_rready", axi_req.rready, 0);
        check_eq("mid_rst_data_ok", dbus_if.data_ok, 0);
        check_eq("mid_rst_addr_ok", dbus_if.addr_ok, 1);
        tick();
        tick();
        resetn = 1'b1;
        r_wait = 0;
        tick();
        rd_word = 32'h7777_0001;
        run_req("post_rst_rd", 1'b0, 32'h1faf_f044, 2'd2, 32'h0, 4'h0, 2, 1'b0, 32'h7777_0001,
                1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dbus_uncache_axi.md
Name: dbus_uncache_axi

Overview:
- Bridges the uncached side of the data bus to the AXI master port.
- Slave side takes cpu_dbus_if.slave requests with uncache=1 (D$ miss path or CPU MMIO), one at a time.
- Each request becomes exactly one single-beat AXI read or write, driven through axi_req_t / axi_resp_t.
- Sits directly downstream of the CPU/D$ dbus and upstream of the SoC AXI crossbar.

Parameters:
- AXI_CACHE, 4'b0000, value driven on arcache/awcache (device, non-bufferable).
- AXI_PROT, 3'b000, value driven on arprot/awprot.

Ports:
- clk  input  1  system clock; all logic on posedge.
- resetn  input  1  asynchronous, active-low reset.
- dbus  interface  cpu_dbus_if.slave  request side (valid, op, uncache, address, size, wdata, wstrb in; addr_ok, data_ok, rdata out).
- axi_req  output  axi_req_t  AR/R/AW/W/B master signals.
- axi_resp  input  axi_resp_t  AXI slave responses.
- bus_err  output  1  one-cycle pulse, coincident with data_ok, when rresp/bresp != 2'b00.

Behaviour:
- Clock is clk; reset is resetn, asynchronous assert, active-low. Already decided.
- Reset values: FSM=IDLE, and all of the following are 0: addr_ok, data_ok, bus_err, rdata, arvalid, rready, awvalid, wvalid, bready, wlast.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - addr_ok = 1, combinational from state only.
  - On valid & addr_ok, latch address, size, op, wdata, wstrb.
  - Go to RD_ADDR if op=0, else WR_REQ.
  - A request with uncache=0 is still serviced; the owner must not send it.
- RD_ADDR:
  - arvalid=1, araddr=latched address, arlen=0, arsize={1'b0,size}, arburst=2'b01, arlock=0, arcache=AXI_CACHE, arprot=AXI_PROT.
  - On arready, go to RD_DATA.
  - arvalid and all AR fields stay stable until the handshake.
- RD_DATA:
  - rready=1.
  - On rvalid, register rdata, err=(rresp!=0), go to DONE.
  - rlast is ignored; the burst is one beat by construction.
- WR_REQ:
  - awvalid and wvalid are asserted together in the first WR_REQ cycle.
  - awaddr/awsize/awburst/etc. follow the same encoding as AR; wdata/wstrb come from the latch, wlast=1.
  - aw_done and w_done flags track each handshake independently. awvalid drops after awready; wvalid drops after wready.
  - AW before W, W before AW, and same-cycle handshakes are all legal.
  - When both are done, clear the flags and go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid, err=(bresp!=0), go to DONE.
- DONE:
  - data_ok=1 and bus_err=err for exactly one cycle.
  - rdata holds the registered read data (value undefined but stable for writes).
  - Next state is IDLE.
  - No new request is accepted in DONE, so minimum turnaround is 1 cycle.
- Timing:
  - Read latency from accept to data_ok = 2 + AR wait + R wait cycles.
  - Zero-wait read: accept at T0, arvalid at T1, rvalid at T2, data_ok at T3.
- Only one outstanding transaction at a time; addr_ok=0 in every state except IDLE.
- Ordering is strict, trivially, because only one transaction is ever in flight.
- rdata stays valid after data_ok until the next read's R handshake.
- Reset mid-transaction: FSM returns to IDLE and the AXI transaction is abandoned. The interconnect shares the reset, so no drain is required.
- No timeout. A hung slave stalls the FSM indefinitely, by design.

Decomposition:
- No new shared types: axi_req_t, axi_resp_t, cpu_dbus_if and phys_t are reused from the common defs header.
- Add to that header: the FSM state enum typedef (uncache_state_t) and AXI constants AXI_BURST_INCR=2'b01 and AXI_RESP_OKAY=2'b00.
- Single module; no sub-module is warranted.

Test Plan:
- Read, zero-wait:
  - Stimulus: addr 0x1faf_f000, size 2, slave returns 0xdead_beef with rresp=0.
  - Required: araddr=0x1faf_f000, arsize=3'b010, arlen=0; data_ok at T3 with rdata=0xdead_beef; bus_err=0.
- Write, AW accepted 3 cycles before W:
  - Stimulus: addr 0x1faf_f004, wdata 0x1234_5678, wstrb 4'b0011.
  - Required: awvalid drops after awready while wvalid is held; wlast=1; one data_ok after bvalid; no duplicate AW.
- Write, W accepted before AW, and same-cycle AW/W:
  - Required: exactly one AW and one W handshake each; data_ok one cycle after bvalid.
- Back-to-back requests with valid held high:
  - Required: addr_ok=0 from accept through DONE; second request accepted only in the IDLE cycle after data_ok.
- Error response:
  - Stimulus: rresp=2'b10, then bresp=2'b11.
  - Required: bus_err=1 coincident with data_ok, 0 otherwise.
- Reset mid-transaction:
  - Stimulus: resetn low while in RD_DATA with rvalid=0.
  - Required: arvalid, rready and data_ok go to 0 immediately (asynchronously); after resetn rises, addr_ok=1 and the next read completes normally.
